// File: rtl/mem_stage.sv
// Memory stage: single-outstanding data-memory access with byte/half/word lanes,
// bus-timeout abort and registered write-back outputs towards WB.
module mem_stage #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] Instr1_IN,
    input  logic [31:0] Instr1_PC_IN,
    input  logic [31:0] ALU_result1_IN,
    input  logic [4:0]  WriteRegister1_IN,
    input  logic        RegWrite1_IN,
    input  logic [31:0] MemWriteData1_IN,
    input  logic        MemRead1_IN,
    input  logic        MemWrite1_IN,
    input  logic [1:0]  MemSize1_IN,
    input  logic        MemSigned1_IN,
    output logic        STALL,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic [31:0] Instr1_OUT,
    output logic [31:0] Instr1_PC_OUT,
    output logic [31:0] WriteData1_OUT,
    output logic [4:0]  WriteRegister1_OUT,
    output logic        RegWrite1_OUT,
    output logic [1:0]  MemErr_OUT,
    output logic        o_state_dbg
);
    typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      r_state, w_next_state;
    logic [7:0]  r_cnt;
    logic [1:0]  r_lane, r_size;
    logic        r_sign, r_we;
    logic [31:0] r_addr, r_wdata;
    logic [3:0]  r_be;

    logic        w_memop, w_illegal, w_misal, w_start, w_timeout, w_ack;
    logic [3:0]  w_be;
    logic [31:0] w_wdata, w_load;
    logic [7:0]  w_rbyte;
    logic [15:0] w_rhalf;

    assign w_memop   = MemRead1_IN | MemWrite1_IN;
    assign w_illegal = MemRead1_IN & MemWrite1_IN;
    assign w_misal   = w_memop & ~w_illegal &
                       (((MemSize1_IN == 2'b01) & ALU_result1_IN[0]) |
                        (MemSize1_IN[1] & (ALU_result1_IN[1:0] != 2'b00)));
    assign w_start   = (r_state == S_IDLE) & w_memop & ~w_illegal & ~w_misal;
    assign w_timeout = (r_state == S_WAIT) & (r_cnt == TO_LAST);
    assign w_ack     = (r_state == S_WAIT) & dmem_ack;

    // STALL is forced low during reset even if upstream still presents a memory op.
    assign STALL = RESET & (w_start | ((r_state == S_WAIT) & ~dmem_ack & ~w_timeout));

    assign dmem_req    = (r_state == S_WAIT);
    assign dmem_we     = (r_state == S_WAIT) & r_we;
    assign dmem_addr   = r_addr;
    assign dmem_wdata  = r_wdata;
    assign dmem_be     = r_be;
    assign o_state_dbg = r_state;

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = MemWriteData1_IN;
        if (MemWrite1_IN) begin
            case (MemSize1_IN)
                2'b00: begin
                    w_be    = 4'b0001 << ALU_result1_IN[1:0];
                    w_wdata = {4{MemWriteData1_IN[7:0]}};
                end
                2'b01: begin
                    w_be    = ALU_result1_IN[1] ? 4'b1100 : 4'b0011;
                    w_wdata = {2{MemWriteData1_IN[15:0]}};
                end
                default: begin
                    w_be    = 4'b1111;
                    w_wdata = MemWriteData1_IN;
                end
            endcase
        end
    end

    assign w_rbyte = dmem_rdata[{r_lane, 3'b000} +: 8];
    assign w_rhalf = dmem_rdata[{r_lane[1], 4'b0000} +: 16];

    always_comb begin
        w_load = dmem_rdata;
        case (r_size)
            2'b00:   w_load = {{24{r_sign & w_rbyte[7]}}, w_rbyte};
            2'b01:   w_load = {{16{r_sign & w_rhalf[15]}}, w_rhalf};
            default: w_load = dmem_rdata;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_next_state = S_WAIT;
            S_WAIT:  if (w_ack || w_timeout) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state            <= S_IDLE;
            r_cnt              <= 8'd0;
            r_lane             <= 2'b00;
            r_size             <= 2'b00;
            r_sign             <= 1'b0;
            r_we               <= 1'b0;
            r_addr             <= 32'd0;
            r_wdata            <= 32'd0;
            r_be               <= 4'd0;
            Instr1_OUT         <= 32'd0;
            Instr1_PC_OUT      <= 32'd0;
            WriteData1_OUT     <= 32'd0;
            WriteRegister1_OUT <= 5'd0;
            RegWrite1_OUT      <= 1'b0;
            MemErr_OUT         <= 2'b00;
        end else begin
            r_state            <= w_next_state;
            MemErr_OUT         <= 2'b00;
            Instr1_OUT         <= 32'd0;
            Instr1_PC_OUT      <= 32'd0;
            WriteData1_OUT     <= 32'd0;
            WriteRegister1_OUT <= 5'd0;
            RegWrite1_OUT      <= 1'b0;
            if (w_start) begin
                r_addr  <= {ALU_result1_IN[31:2], 2'b00};
                r_lane  <= ALU_result1_IN[1:0];
                r_size  <= MemSize1_IN;
                r_sign  <= MemSigned1_IN;
                r_we    <= MemWrite1_IN;
                r_wdata <= w_wdata;
                r_be    <= w_be;
                r_cnt   <= 8'd0;
            end else if (r_state == S_IDLE || w_ack || w_timeout) begin
                // Retirement: upstream still holds the instruction's inputs here.
                Instr1_OUT         <= Instr1_IN;
                Instr1_PC_OUT      <= Instr1_PC_IN;
                WriteRegister1_OUT <= WriteRegister1_IN;
                WriteData1_OUT     <= (w_ack && !r_we) ? w_load : ALU_result1_IN;
                if (r_state == S_IDLE) begin
                    RegWrite1_OUT <= RegWrite1_IN & ~w_illegal & ~w_misal;
                    if (w_illegal)    MemErr_OUT <= 2'b11;
                    else if (w_misal) MemErr_OUT <= 2'b01;
                end else if (w_ack) begin
                    RegWrite1_OUT <= RegWrite1_IN;
                end else begin
                    MemErr_OUT <= 2'b10;
                end
            end else begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// Randomized and directed bench for mem_stage; expected results come from a
// transaction-level model of lane selection, extension, alignment and timeout rules.
module tb_mem_stage;
    localparam int TO = 4;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic [31:0] Instr1_IN = '0, Instr1_PC_IN = '0, ALU_result1_IN = '0, MemWriteData1_IN = '0;
    logic [4:0]  WriteRegister1_IN = '0;
    logic        RegWrite1_IN = 1'b0, MemRead1_IN = 1'b0, MemWrite1_IN = 1'b0, MemSigned1_IN = 1'b0;
    logic [1:0]  MemSize1_IN = '0;
    logic        STALL, dmem_req, dmem_we, dmem_ack = 1'b0;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = '0;
    logic [3:0]  dmem_be;
    logic [31:0] Instr1_OUT, Instr1_PC_OUT, WriteData1_OUT;
    logic [4:0]  WriteRegister1_OUT;
    logic        RegWrite1_OUT, o_state_dbg;
    logic [1:0]  MemErr_OUT;

    int total = 0;
    int bad = 0;

    mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .CLK(CLK), .RESET(RESET),
        .Instr1_IN(Instr1_IN), .Instr1_PC_IN(Instr1_PC_IN), .ALU_result1_IN(ALU_result1_IN),
        .WriteRegister1_IN(WriteRegister1_IN), .RegWrite1_IN(RegWrite1_IN),
        .MemWriteData1_IN(MemWriteData1_IN), .MemRead1_IN(MemRead1_IN), .MemWrite1_IN(MemWrite1_IN),
        .MemSize1_IN(MemSize1_IN), .MemSigned1_IN(MemSigned1_IN), .STALL(STALL),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_be(dmem_be), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .Instr1_OUT(Instr1_OUT), .Instr1_PC_OUT(Instr1_PC_OUT), .WriteData1_OUT(WriteData1_OUT),
        .WriteRegister1_OUT(WriteRegister1_OUT), .RegWrite1_OUT(RegWrite1_OUT),
        .MemErr_OUT(MemErr_OUT), .o_state_dbg(o_state_dbg)
    );

    always #5 CLK = ~CLK;

    task automatic clear_inputs();
        Instr1_IN = '0; Instr1_PC_IN = '0; ALU_result1_IN = '0; MemWriteData1_IN = '0;
        WriteRegister1_IN = '0; RegWrite1_IN = 0; MemRead1_IN = 0; MemWrite1_IN = 0;
        MemSize1_IN = '0; MemSigned1_IN = 0;
    endtask

    // One instruction through the stage; called at a negedge, returns at a negedge.
    // delay = WAIT cycles before ack (ack in WAIT cycle delay+1); delay >= TO means no ack.
    task automatic run_txn(input logic rd_en, input logic wr_en, input logic [1:0] size,
                           input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int delay, input logic [4:0] rd,
                           input logic rw, input logic [31:0] instr, input logic [31:0] pc);
        logic illegal, misal, legal, acked;
        logic [31:0] exp_wd, exp_wdata, v;
        logic [3:0]  exp_be;
        logic [1:0]  exp_err;
        logic        exp_rw;
        int off, stalls, exp_stalls, last;
        off     = int'(addr % 4);
        illegal = rd_en && wr_en;
        misal   = (rd_en || wr_en) && !illegal &&
                  ((size == 2'd1 && (addr % 2) != 0) || (size >= 2'd2 && off != 0));
        legal   = (rd_en || wr_en) && !illegal && !misal;
        acked   = legal && (delay < TO);
        last    = acked ? delay : TO - 1;
        exp_stalls = legal ? 1 + last : 0;
        exp_be = 4'hF; exp_wdata = wdata;
        if (wr_en && size == 2'd0) begin exp_be = 4'(1 << off); exp_wdata = (wdata & 32'hFF) * 32'h01010101; end
        if (wr_en && size == 2'd1) begin exp_be = (off >= 2) ? 4'hC : 4'h3; exp_wdata = (wdata & 32'hFFFF) * 32'h00010001; end
        exp_wd = addr;
        if (acked && rd_en) begin
            if (size == 2'd0) begin
                v = (rdata >> (8 * off)) & 32'hFF;
                exp_wd = (sgn && v >= 32'd128) ? v - 32'd256 : v;
            end else if (size == 2'd1) begin
                v = (rdata >> (16 * (off / 2))) & 32'hFFFF;
                exp_wd = (sgn && v >= 32'd32768) ? v - 32'd65536 : v;
            end else exp_wd = rdata;
        end
        exp_rw  = rw && !illegal && !misal && !(legal && !acked);
        exp_err = illegal ? 2'b11 : misal ? 2'b01 : (legal && !acked) ? 2'b10 : 2'b00;

        Instr1_IN = instr; Instr1_PC_IN = pc; ALU_result1_IN = addr; MemWriteData1_IN = wdata;
        WriteRegister1_IN = rd; RegWrite1_IN = rw; MemRead1_IN = rd_en; MemWrite1_IN = wr_en;
        MemSize1_IN = size; MemSigned1_IN = sgn;
        #1;
        stalls = STALL ? 1 : 0;
        total++;
        if (STALL !== legal) begin bad++; $display("FAIL idle_stall got=%b exp=%b", STALL, legal); end
        @(posedge CLK); @(negedge CLK);
        if (legal) begin
            for (int k = 0; k <= last; k++) begin
                dmem_ack = 1'b0;
                total++;
                if (dmem_req !== 1'b1 || dmem_we !== wr_en || dmem_addr !== (addr - 32'(off)) ||
                    dmem_be !== exp_be || (wr_en && dmem_wdata !== exp_wdata)) begin
                    bad++;
                    $display("FAIL wait_bus k=%0d got req=%b we=%b a=%h be=%b wd=%h exp we=%b a=%h be=%b wd=%h",
                             k, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, wr_en, addr - 32'(off), exp_be, exp_wdata);
                end
                total++;
                if (RegWrite1_OUT !== 1'b0 || WriteData1_OUT !== 32'd0 || MemErr_OUT !== 2'b00) begin
                    bad++; $display("FAIL wait_bubble k=%0d got rw=%b wd=%h err=%b exp 0", k, RegWrite1_OUT, WriteData1_OUT, MemErr_OUT);
                end
                dmem_rdata = (acked && k == delay) ? rdata : $urandom;
                dmem_ack   = acked && (k == delay);
                #1;
                if (STALL) stalls++;
                total++;
                if (STALL !== (k != last)) begin bad++; $display("FAIL wait_stall k=%0d got=%b exp=%b", k, STALL, k != last); end
                @(posedge CLK); @(negedge CLK);
            end
            dmem_ack = 1'b0;
        end
        total++;
        if (stalls != exp_stalls) begin bad++; $display("FAIL stall_count got=%0d exp=%0d", stalls, exp_stalls); end
        total++;
        if (dmem_req !== 1'b0) begin bad++; $display("FAIL req_after got=%b exp=0", dmem_req); end
        total++;
        if (RegWrite1_OUT !== exp_rw || MemErr_OUT !== exp_err) begin
            bad++; $display("FAIL retire_ctl got rw=%b err=%b exp rw=%b err=%b", RegWrite1_OUT, MemErr_OUT, exp_rw, exp_err);
        end
        if (exp_err == 2'b00) begin
            total++;
            if (WriteData1_OUT !== exp_wd || Instr1_OUT !== instr || Instr1_PC_OUT !== pc || WriteRegister1_OUT !== rd) begin
                bad++;
                $display("FAIL retire_data got wd=%h ins=%h pc=%h rd=%0d exp wd=%h ins=%h pc=%h rd=%0d",
                         WriteData1_OUT, Instr1_OUT, Instr1_PC_OUT, WriteRegister1_OUT, exp_wd, instr, pc, rd);
            end
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        MemRead1_IN = 1; MemSize1_IN = 2'd2; ALU_result1_IN = 32'h100;
        repeat (2) @(negedge CLK);
        #1;
        total++;
        if (STALL !== 0 || dmem_req !== 0 || dmem_we !== 0 || dmem_be !== 0 || dmem_addr !== 0 || dmem_wdata !== 0) begin
            bad++; $display("FAIL reset_bus got stall=%b req=%b we=%b be=%b a=%h wd=%h exp all 0", STALL, dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata);
        end
        total++;
        if (Instr1_OUT !== 0 || Instr1_PC_OUT !== 0 || WriteData1_OUT !== 0 || WriteRegister1_OUT !== 0 ||
            RegWrite1_OUT !== 0 || MemErr_OUT !== 0 || o_state_dbg !== 0) begin
            bad++; $display("FAIL reset_wb got wd=%h rw=%b err=%b st=%b exp 0", WriteData1_OUT, RegWrite1_OUT, MemErr_OUT, o_state_dbg);
        end
        clear_inputs();
        @(negedge CLK);
        RESET = 1'b1;
    endtask

    task automatic test_alu();
        run_txn(0, 0, 2'd2, 0, 32'h1234, 32'h0, 32'h0, 0, 5'd5, 1, 32'h00A00093, 32'h40);
        dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
        run_txn(0, 0, 2'd0, 0, 32'hCAFE0001, 32'h0, 32'h0, 0, 5'd9, 1, 32'h11, 32'h44);
        dmem_ack = 1'b0;
    endtask

    task automatic test_loads_stores();
        run_txn(1, 0, 2'd0, 1, 32'h103, 32'h0, 32'h80FFFFFF, 3, 5'd7, 1, 32'h3, 32'h48);
        run_txn(0, 1, 2'd1, 0, 32'h102, 32'h0000BEEF, 32'h0, 0, 5'd0, 0, 32'h23, 32'h4C);
        run_txn(1, 0, 2'd1, 0, 32'h202, 32'h0, 32'h9ABC1234, 1, 5'd8, 1, 32'h5, 32'h50);
        run_txn(0, 1, 2'd0, 0, 32'h201, 32'h123456A5, 32'h0, 2, 5'd0, 0, 32'h23, 32'h54);
    endtask

    task automatic test_errors();
        run_txn(1, 0, 2'd2, 0, 32'h101, 32'h0, 32'h0, 0, 5'd3, 1, 32'h3, 32'h58);
        run_txn(0, 0, 2'd2, 0, 32'h0, 32'h0, 32'h0, 0, 5'd0, 0, 32'h0, 32'h5C);
        run_txn(1, 1, 2'd2, 0, 32'h100, 32'h0, 32'h0, 0, 5'd3, 1, 32'h3, 32'h60);
        run_txn(0, 1, 2'd3, 0, 32'h10E, 32'h0, 32'h0, 0, 5'd0, 0, 32'h23, 32'h64);
    endtask

    task automatic test_timeout();
        run_txn(1, 0, 2'd2, 0, 32'h300, 32'h0, 32'h0, TO + 3, 5'd4, 1, 32'h3, 32'h68);
        run_txn(1, 0, 2'd2, 0, 32'h304, 32'h0, 32'h55AA1234, TO - 1, 5'd4, 1, 32'h3, 32'h6C);
    endtask

    task automatic test_back_to_back();
        run_txn(0, 1, 2'd2, 0, 32'h400, 32'hA5A5F00D, 32'h0, 0, 5'd0, 0, 32'h23, 32'h70);
        run_txn(1, 0, 2'd2, 0, 32'h400, 32'h0, 32'hA5A5F00D, 0, 5'd6, 1, 32'h3, 32'h74);
        run_txn(1, 0, 2'd1, 1, 32'h402, 32'h0, 32'h8001FFFF, 0, 5'd7, 1, 32'h3, 32'h78);
        run_txn(1, 0, 2'd0, 0, 32'h401, 32'h0, 32'h0000F200, 0, 5'd8, 1, 32'h3, 32'h7C);
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            int op;
            op = $urandom_range(0, 4);
            run_txn(op == 1 || op == 3 || (op == 4 && $urandom_range(0, 1) == 1), op == 2 || op == 3,
                    2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 32'h1000 + $urandom_range(0, 63),
                    $urandom, $urandom, $urandom_range(0, TO + 1), 5'($urandom_range(0, 31)),
                    1'($urandom_range(0, 1)), $urandom, $urandom);
        end
    endtask

    task automatic test_reset_mid_wait();
        Instr1_IN = 32'h3; ALU_result1_IN = 32'h500; MemRead1_IN = 1; MemSize1_IN = 2'd2;
        RegWrite1_IN = 1; WriteRegister1_IN = 5'd10;
        @(posedge CLK); @(negedge CLK);
        total++;
        if (dmem_req !== 1'b1) begin bad++; $display("FAIL midwait_req got=%b exp=1", dmem_req); end
        #2 RESET = 1'b0;
        #1;
        total++;
        if (dmem_req !== 1'b0 || STALL !== 1'b0) begin bad++; $display("FAIL async_drop got req=%b stall=%b exp 0 0", dmem_req, STALL); end
        clear_inputs();
        @(negedge CLK);
        RESET = 1'b1; dmem_ack = 1'b1; dmem_rdata = 32'h77777777;
        @(posedge CLK); @(negedge CLK);
        dmem_ack = 1'b0;
        total++;
        if (dmem_req !== 0 || RegWrite1_OUT !== 0 || WriteData1_OUT !== 0 || MemErr_OUT !== 0) begin
            bad++; $display("FAIL late_ack got req=%b rw=%b wd=%h err=%b exp 0", dmem_req, RegWrite1_OUT, WriteData1_OUT, MemErr_OUT);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_loads_stores();
        test_errors();
        test_timeout();
        test_back_to_back();
        test_random();
        test_reset_mid_wait();
        run_txn(1, 0, 2'd2, 0, 32'h600, 32'h0, 32'h01020304, 1, 5'd2, 1, 32'h3, 32'h80);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL provide parameter TIMEOUT_CYCLES, default 64, max WAIT cycles before bus-error abort (1..255).
REQ-002 SHALL have CLK  input  1  clock; all state updates on posedge CLK.
REQ-003 SHALL have RESET  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have Instr1_IN / Instr1_PC_IN  input  32 each  debug instruction/PC from EXE.
REQ-005 SHALL have ALU_result1_IN  input  32  ALU result or memory byte address.
REQ-006 SHALL have WriteRegister1_IN  input  5, and RegWrite1_IN  input  1  destination register and write enable.
REQ-007 SHALL have MemWriteData1_IN  input  32  store data.
REQ-008 SHALL have MemRead1_IN / MemWrite1_IN  input  1 each  load/store request.
REQ-009 SHALL have MemSize1_IN  input  2  00 byte, 01 half, 10 word, 11 reserved (treated as word); MemSigned1_IN  input  1  sign-extend loads.
REQ-010 SHALL have STALL  output  1  combinational; upstream holds all inputs while high.
REQ-011 SHALL have dmem_req, dmem_we  output  1; dmem_addr  output  32 (word-aligned); dmem_wdata  output  32; dmem_be  output  4.
REQ-012 SHALL have dmem_rdata  input  32, dmem_ack  input  1  (ack valid only while dmem_req=1).
REQ-013 SHALL have Instr1_OUT, Instr1_PC_OUT, WriteData1_OUT  output  32; WriteRegister1_OUT  output  5; RegWrite1_OUT  output  1  registered to WB; WriteData1_OUT also feeds EXE MEM/WB forwarding.
REQ-014 SHALL have MemErr_OUT  output  2  registered one-cycle pulse: 01 misaligned, 10 timeout, 11 illegal (read and write both high).

Function
REQ-015 SHALL implement FSM states IDLE and WAIT.
REQ-016 IDLE, no memory op: next posedge registers inputs to WB outputs, WriteData1_OUT=ALU_result1_IN, STALL=0 (latency 1).
REQ-017 IDLE, legal aligned op: STALL=1; next posedge latches word address (addr[31:2],00), lane, size, sign, wdata/be, enters WAIT, TIMEOUT counter cleared, WB outputs get bubble (all zero).
REQ-018 WAIT: dmem_req=1, dmem_we=latched store flag; addr/wdata/be stable until ack; STALL=!dmem_ack.
REQ-019 WAIT with dmem_ack: posedge retires instruction to WB, returns IDLE, dmem_req deasserts; minimum load/store latency 2 cycles.
REQ-020 WAIT without ack: posedge increments counter, WB outputs bubble.
REQ-021 Counter reaching TIMEOUT_CYCLES without ack: posedge returns IDLE, retires with RegWrite1_OUT=0, MemErr_OUT=10; STALL low that cycle.
REQ-022 Ack and timeout in same cycle: ack wins, no error.
REQ-023 Misalignment (half addr[0]=1; word addr[1:0]!=0): no request, no stall, retire next posedge with RegWrite1_OUT=0, MemErr_OUT=01.
REQ-024 MemRead1_IN and MemWrite1_IN both high: no request, retire with RegWrite1_OUT=0, MemErr_OUT=11.
REQ-025 Little-endian lanes: byte lane=addr[1:0], half lane=addr[1]; load data zero- or sign-extended per MemSigned1_IN to 32 bits into WriteData1_OUT.
REQ-026 Stores: SB be=0001<<addr[1:0], wdata=byte replicated x4; SH be=0011 or 1100, wdata=half replicated x2; SW be=1111; WriteData1_OUT=ALU_result1_IN, RegWrite1_OUT passed through.
REQ-027 Loads drive dmem_be=1111 and dmem_we=0.
REQ-028 dmem_ack while dmem_req=0 SHALL be ignored.

Reset
REQ-029 RESET low SHALL immediately force IDLE, counter 0, dmem_req=0, dmem_we=0, dmem_be=0, dmem_addr=0, dmem_wdata=0, STALL=0, all WB outputs 0, MemErr_OUT=00.
REQ-030 Reset during WAIT SHALL abandon the access; late acks ignored.

Verification
REQ-031 ALU op, ALU_result1_IN=0x1234, RegWrite=1, rd=5 -> next cycle WriteData1_OUT=0x1234, RegWrite1_OUT=1, STALL never high.
REQ-032 LB signed addr=0x103, ack after 3 WAIT cycles, rdata=0x80FFFFFF -> STALL high 4 cycles, dmem_addr=0x100, WriteData1_OUT=0xFFFFFF80.
REQ-033 SH addr=0x102, data=0x0000BEEF, ack in first WAIT cycle -> dmem_be=1100, dmem_wdata=0xBEEFBEEF, dmem_we=1, retire after 2 cycles.
REQ-034 LW addr=0x101 -> no dmem_req, MemErr_OUT=01 one cycle, RegWrite1_OUT=0.
REQ-035 LW, no ack, TIMEOUT_CYCLES=4 -> req high 4 cycles, then MemErr_OUT=10, RegWrite1_OUT=0; repeat with ack on 4th cycle -> no error.
REQ-036 RESET asserted mid-WAIT -> dmem_req and STALL drop asynchronously; ack next cycle produces no retirement.
